mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of memory_rtl. Accepts one
//  read or write at a time from requester 0 or 1, drives the memory strobe/addr/wdata,
//  waits for the memory's response, and returns read data (or a timeout error) to the
//  winning requester. Sits between the two masters and the single memory port.
// PARAMETERS
//  ADDR_WIDTH  4   memory address width
//  DATA_WIDTH  32  memory data width
//  TIMEOUT     16  max cycles in ISSUE waiting for mem_response (>=2); counter is $clog2(TIMEOUT)+1 bits
// PORTS
//  clk            in   1           clock, all logic on posedge
//  reset          in   1           synchronous, active-high
//  mN_valid       in   1           requester N (N=0,1) has a request; held until mN_ready
//  mN_wr          in   1           1=write, 0=read; stable while mN_valid
//  mN_addr        in   ADDR_WIDTH  request address; stable while mN_valid
//  mN_wdata       in   DATA_WIDTH  write data; stable while mN_valid
//  mN_ready       out  1           one-cycle accept pulse for requester N
//  mN_resp_valid  out  1           one-cycle completion pulse for requester N
//  mN_resp_rdata  out  DATA_WIDTH  read data, valid with mN_resp_valid (0 for writes/errors)
//  mN_resp_err    out  1           1=timeout, valid with mN_resp_valid
//  mem_wr         out  1           to memory_rtl wr
//  mem_rd         out  1           to memory_rtl rd
//  mem_addr       out  ADDR_WIDTH  to memory_rtl addr
//  mem_wdata      out  DATA_WIDTH  to memory_rtl wdata
//  mem_rdata      in   DATA_WIDTH  from memory_rtl rdata, sampled when mem_response=1
//  mem_response   in   1           from memory_rtl response
// BEHAVIOUR
//  - Reset: every output 0; state=IDLE; last_grant=1 (requester 0 wins first tie); counter=0.
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE. All outputs registered.
//  - IDLE: if only one mN_valid, grant it; if both, grant the one != last_grant. Grant cycle:
//    mN_ready=1 next cycle edge-registered with capture of wr/addr/wdata, last_grant=N, go ISSUE.
//    mN_ready high exactly one cycle (the first ISSUE cycle); requester drops/changes valid after.
//  - ISSUE: mem_wr=wr, mem_rd=!wr, mem_addr/mem_wdata=latched values, held constant.
//    mem_wr and mem_rd never both 1. Counter increments each ISSUE cycle.
//    * mem_response=1: capture mem_rdata (reads) else 0, err=0, strobes to 0, go RESP.
//    * counter==TIMEOUT-1 without response: rdata=0, err=1, strobes to 0, go RESP.
//    * response and timeout in same cycle: response wins (err=0).
//  - RESP: mN_resp_valid=1 for granted N only, with rdata/err, one cycle; go IDLE; counter=0.
//  - Throughput: min 3 cycles per access (IDLE, ISSUE>=1, RESP); first strobe 1 cycle after grant.
//  - mem_response outside ISSUE is ignored (no state change, no resp pulse).
//  - Requests arriving while busy wait in mN_valid; no queuing inside the block.
//  - Reset mid-operation (any state): abort, strobes drop next edge, no resp_valid issued.
//  - Unused outputs (other requester's resp fields, mem_addr/wdata in IDLE) driven 0.
// TESTING
//  1 m0 write addr=3 wdata=32'hDEAD_BEEF, mem responds 1 cycle later -> m0_ready 1 pulse,
//    mem_wr=1 addr=3 until response, m0_resp_valid=1 err=0 rdata=0, mem_rd never 1.
//  2 m1 read addr=3 after test 1, memory returns 32'hDEAD_BEEF -> m1_resp_rdata=32'hDEAD_BEEF, err=0.
//  3 m0 and m1 valid same cycle from reset, both held -> grants 0,1,0,1 alternate; each gets
//    exactly one ready and one resp pulse per access; no overlap of strobes.
//  4 m0 read addr=5, mem_response held 0 -> strobe drops after 16 ISSUE cycles, m0_resp_valid=1,
//    err=1, rdata=0; next request served normally.
//  5 reset asserted during ISSUE of m1 write -> next cycle all outputs 0, no m1_resp_valid;
//    stray mem_response in IDLE produces no response pulse.
//  6 response on final timeout cycle (cycle 16) -> err=0, rdata captured.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin sequencer for a single memory port (ports: clk, reset, m0_*/m1_* request/response, mem_* memory side)
module mem_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_valid,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic                  m0_resp_valid,
  output logic [DATA_WIDTH-1:0] m0_resp_rdata,
  output logic                  m0_resp_err,
  input  logic                  m1_valid,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic                  m1_resp_valid,
  output logic [DATA_WIDTH-1:0] m1_resp_rdata,
  output logic                  m1_resp_err,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_response
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef struct packed {
    state_t                st;
    logic                  lg;
    logic                  g;
    logic [CW-1:0]         cnt;
    logic                  rdy0;
    logic                  rdy1;
    logic                  rv0;
    logic                  rv1;
    logic                  err0;
    logic                  err1;
    logic [DATA_WIDTH-1:0] rd0;
    logic [DATA_WIDTH-1:0] rd1;
    logic                  mwr;
    logic                  mrd;
    logic [ADDR_WIDTH-1:0] maddr;
    logic [DATA_WIDTH-1:0] mwdata;
  } regs_t;
  regs_t r, rn;
  logic g, wr, done;
  always_comb begin
    rn = r;
    rn.rdy0 = 1'b0;
    rn.rdy1 = 1'b0;
    rn.rv0 = 1'b0;
    rn.rv1 = 1'b0;
    rn.err0 = 1'b0;
    rn.err1 = 1'b0;
    rn.rd0 = '0;
    rn.rd1 = '0;
    g = (m0_valid && m1_valid) ? !r.lg : m1_valid;
    wr = g ? m1_wr : m0_wr;
    done = mem_response || r.cnt == CW'(TIMEOUT - 1);
    case (r.st)
      IDLE: if (m0_valid || m1_valid) begin
        rn.st = ISSUE;
        rn.lg = g;
        rn.g = g;
        rn.cnt = '0;
        rn.rdy0 = !g;
        rn.rdy1 = g;
        rn.mwr = wr;
        rn.mrd = !wr;
        rn.maddr = g ? m1_addr : m0_addr;
        rn.mwdata = g ? m1_wdata : m0_wdata;
      end
      ISSUE: begin
        rn.cnt = r.cnt + 1'b1;
        if (done) begin
          rn.st = RESP;
          rn.mwr = 1'b0;
          rn.mrd = 1'b0;
          rn.maddr = '0;
          rn.mwdata = '0;
          rn.rv0 = !r.g;
          rn.rv1 = r.g;
          rn.err0 = !r.g && !mem_response;
          rn.err1 = r.g && !mem_response;
          rn.rd0 = (!r.g && mem_response && r.mrd) ? mem_rdata : '0;
          rn.rd1 = (r.g && mem_response && r.mrd) ? mem_rdata : '0;
        end
      end
      RESP: begin
        rn.st = IDLE;
        rn.cnt = '0;
      end
      default: rn.st = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0;
      r.lg <= 1'b1;
    end else begin
      r <= rn;
    end
  end
  assign m0_ready = r.rdy0;
  assign m1_ready = r.rdy1;
  assign m0_resp_valid = r.rv0;
  assign m1_resp_valid = r.rv1;
  assign m0_resp_err = r.err0;
  assign m1_resp_err = r.err1;
  assign m0_resp_rdata = r.rd0;
  assign m1_resp_rdata = r.rd1;
  assign mem_wr = r.mwr;
  assign mem_rd = r.mrd;
  assign mem_addr = r.maddr;
  assign mem_wdata = r.mwdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven bench for mem_arbiter with a behavioural memory model
module tb_mem_arbiter;
  logic clk = 0, reset = 1;
  logic m0_valid = 0, m0_wr = 0, m1_valid = 0, m1_wr = 0;
  logic [3:0] m0_addr = 0, m1_addr = 0, mem_addr;
  logic [31:0] m0_wdata = 0, m1_wdata = 0, mem_wdata, m0_resp_rdata, m1_resp_rdata;
  logic [31:0] mem_rdata = 0;
  logic m0_ready, m1_ready, m0_resp_valid, m1_resp_valid, m0_resp_err, m1_resp_err;
  logic mem_wr, mem_rd, mem_response = 0;
  int checks = 0, errors = 0;
  logic [31:0] mem [16];
  int lat = 1, scnt = 0;
  logic stray = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_resp_valid(m0_resp_valid), .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
    .m1_valid(m1_valid), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_resp_valid(m1_resp_valid), .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_response(mem_response)
  );

  always #5 clk = ~clk;

  // memory answers after `lat` strobe cycles; garbage on rdata otherwise
  always @(negedge clk) begin
    if (mem_wr || mem_rd) begin
      scnt++;
      mem_response = (scnt == lat);
      if (mem_response && mem_wr) mem[mem_addr] = mem_wdata;
      mem_rdata = (mem_response && mem_rd) ? mem[mem_addr] : 32'hBAD0_BAD0;
    end else begin
      scnt = 0;
      mem_response = stray;
      mem_rdata = 32'hBAD0_BAD0;
    end
  end

  typedef struct {
    logic v0, v1, wr0, wr1;
    logic [3:0] a0, a1;
    logic [31:0] d0, d1;
    int lat;
    logic g;
    logic [31:0] rdata;
    logic err;
    int issue;
  } vec_t;
  vec_t vt[12];

  function automatic vec_t mk(logic v0, v1, wr0, wr1, logic [3:0] a0, a1, logic [31:0] d0, d1,
                              int l, logic g, logic [31:0] rd, logic err, int iss);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.wr0 = wr0; v.wr1 = wr1; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.lat = l; v.g = g; v.rdata = rd; v.err = err; v.issue = iss;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{m0_ready, m1_ready, m0_resp_valid, m1_resp_valid, m0_resp_err, m1_resp_err,
             mem_wr, mem_rd, m0_resp_rdata, m1_resp_rdata, mem_addr, mem_wdata};
  endfunction

  task automatic run_vec(vec_t v, string tag);
    logic seen, got, gg, bad;
    int issue;
    m0_valid = v.v0; m0_wr = v.wr0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_valid = v.v1; m1_wr = v.wr1; m1_addr = v.a1; m1_wdata = v.d1;
    lat = v.lat;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = m0_ready | m1_ready;
    end
    chk({tag, "_ready_seen"}, 64'(seen), 64'(1));
    gg = m1_ready;
    bad = m0_ready & m1_ready;
    chk({tag, "_grant"}, 64'(gg), 64'(v.g));
    if (gg) m1_valid = 0; else m0_valid = 0;
    issue = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (mem_wr | mem_rd) begin
        issue++;
        bad |= (mem_wr & mem_rd) | (mem_wr != (gg ? v.wr1 : v.wr0)) |
               (mem_addr != (gg ? v.a1 : v.a0)) | (mem_wdata != (gg ? v.d1 : v.d0));
      end
      @(negedge clk);
      bad |= m0_ready | m1_ready;
      got = m0_resp_valid | m1_resp_valid;
    end
    chk({tag, "_resp_seen"}, 64'(got), 64'(1));
    bad |= (m0_resp_valid & m1_resp_valid) | mem_wr | mem_rd;
    bad |= gg ? (m0_resp_rdata != 0 || m0_resp_err) : (m1_resp_rdata != 0 || m1_resp_err);
    chk({tag, "_resp_who"}, 64'(m1_resp_valid), 64'(v.g));
    chk({tag, "_rdata"}, 64'(gg ? m1_resp_rdata : m0_resp_rdata), 64'(v.rdata));
    chk({tag, "_err"}, 64'(gg ? m1_resp_err : m0_resp_err), 64'(v.err));
    chk({tag, "_issue_cycles"}, 64'(issue), 64'(v.issue));
    chk({tag, "_protocol"}, 64'(bad), 64'(0));
  endtask

  initial begin
    logic seen, bad;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    vt[0]  = mk(1, 0, 1, 0, 3, 0, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 1);
    vt[1]  = mk(1, 1, 1, 1, 3, 4, 32'hDEAD_BEEF, 32'h4444, 1, 1, 0, 0, 1);
    vt[2]  = mk(1, 1, 1, 1, 3, 4, 32'hDEAD_BEEF, 32'h4444, 1, 0, 0, 0, 1);
    vt[3]  = mk(1, 1, 1, 1, 3, 4, 32'hDEAD_BEEF, 32'h4444, 1, 1, 0, 0, 1);
    vt[4]  = mk(1, 1, 1, 1, 3, 4, 32'hDEAD_BEEF, 32'h4444, 1, 0, 0, 0, 1);
    vt[5]  = mk(0, 1, 0, 0, 0, 3, 0, 0, 3, 1, 32'hDEAD_BEEF, 0, 3);
    vt[6]  = mk(1, 0, 0, 0, 4, 0, 0, 0, 2, 0, 32'h4444, 0, 2);
    vt[7]  = mk(1, 0, 0, 0, 5, 0, 0, 0, 17, 0, 0, 1, 16);
    vt[8]  = mk(0, 1, 0, 0, 0, 4, 0, 0, 1, 1, 32'h4444, 0, 1);
    vt[9]  = mk(1, 0, 0, 0, 3, 0, 0, 0, 16, 0, 32'hDEAD_BEEF, 0, 16);
    vt[10] = mk(0, 1, 0, 1, 0, 5, 0, 32'hCAFE_F00D, 16, 1, 0, 0, 16);
    vt[11] = mk(1, 1, 0, 0, 5, 4, 0, 0, 1, 0, 32'hCAFE_F00D, 0, 1);

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(any_out()), 64'(0));
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
      m0_valid = 0;
      m1_valid = 0;
    end

    // reset in the middle of an m1 write that never gets a response
    m1_valid = 1; m1_wr = 1; m1_addr = 9; m1_wdata = 32'h9999; lat = 100;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = m1_ready;
    end
    chk("rst_ready_seen", 64'(seen), 64'(1));
    m1_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_strobe_before", 64'({mem_wr, mem_rd}), 64'(2'b10));
    reset = 1;
    @(negedge clk);
    chk("rst_outputs_cleared", 64'(any_out()), 64'(0));
    reset = 0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      bad |= any_out();
    end
    stray = 1;
    repeat (4) begin
      @(negedge clk);
      bad |= any_out();
    end
    stray = 0;
    @(negedge clk);
    bad |= any_out();
    chk("rst_quiet_and_stray", 64'(bad), 64'(0));
    chk("rst_no_write", 64'(mem[9]), 64'(0));
    run_vec(mk(1, 1, 0, 0, 3, 4, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 1), "post_rst");
    m0_valid = 0;
    m1_valid = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
